pll_rst_seq: RTL

PLL reset and lock-supervision sequencer on the free-running board reference clock, the input clock that also feeds the PLL. It drives the PLL's active-high reset for a fixed hold time and waits for lock with a timeout, retrying a bounded number of times. It debounces lock and releases a system reset request only after lock has been stable. The request goes to the per-clock-domain reset synchronizers in the SoC top. Loss of lock at run time re-asserts the system reset and re-runs the sequence.

---
 rtl/pll_rst_pkg.sv | 26 ++
 rtl/lock_sync.sv | 33 +++
 rtl/pll_rst_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset/lock sequencer.
// Holds the FSM state encoding, the default parameter values and a small
// helper used to size the shared timer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT = 65536;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_MAX_RETRY    = 4;
    localparam int DEF_SYNC_STAGES  = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchronizer for the asynchronous PLL lock indication.
// Ports:
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset, chain clears to 0
//   d      - asynchronous input
//   q      - synchronized output, STAGES cycles behind d
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset and lock-supervision sequencer.
// Holds the PLL in reset, waits for lock with a timeout and bounded retries,
// debounces lock and only then releases the system reset request. Loss of
// lock while running re-asserts the system reset and restarts the sequence.
// Ports:
//   clk        - free-running board reference clock
//   rst_n      - asynchronous active-low reset
//   pll_lock   - raw PLL lock, asynchronous
//   restart    - single-cycle soft restart request
//   pll_rst    - PLL reset, active-high, registered
//   sys_rst_n  - system reset request, active-low, registered
//   lock_fail  - high while retries are exhausted
//   retry_cnt  - failed attempts in the current sequence
//   loss_cnt   - run-time lock losses, saturating
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_RESET_PLL | pll_rst held high for RST_CYCLES cycles
// S_WAIT_LOCK | pll_rst low, waiting for lock up to LOCK_TIMEOUT cycles
// S_STABLE    | lock seen, counting LOCK_STABLE consecutive lock cycles
// S_RUN       | system reset released, watching for lock loss
// S_FAIL      | retries exhausted, PLL held in reset until restart/rst_n
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int TW      = $clog2(TMR_MAX + 1);

    // Terminal counts: the timer starts at 0 on state entry, so the last
    // cycle of an N-cycle interval sees N-1.
    localparam logic [TW-1:0] RST_TC    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_TC = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_TC = TW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

    logic          lock_s;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_cnt_q, retry_cnt_d;
    logic [7:0]    loss_cnt_q, loss_cnt_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          lock_fail_q, lock_fail_d;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;

        if (restart) begin
            state_d     = S_RESET_PLL;
            timer_d     = '0;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (timer_q == RST_TC) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (lock_s) begin
                        state_d = S_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_TC) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        timer_d     = '0;
                        if ((retry_cnt_q + 4'd1) == RETRY_LIM) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RESET_PLL;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_TC) begin
                        state_d     = S_RUN;
                        timer_d     = '0;
                        retry_cnt_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d = S_RESET_PLL;
                        timer_d = '0;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_d = loss_cnt_q + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so each change lands
        // on the edge that enters the state.
        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        lock_fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign lock_fail = lock_fail_q;
    assign retry_cnt = retry_cnt_q;
    assign loss_cnt  = loss_cnt_q;

endmodule
